mac_table_lookup: RTL and testbench

- Read side of the switch MAC table.
- Per-port destination-MAC lookup requests are arbitrated round-robin and compared against the learned table. Each request returns an egress port mask.
- Sits in the core clock domain next to the table writer and consumes its registered switch_table output.
- Its results drive per-port frame forwarding.

---
 rtl/mac_table_lookup_pkg.sv | 29 ++
 rtl/mac_table_lookup_if.sv | 22 ++
 rtl/mac_table_lookup_rr_arbiter.sv | 43 ++++
 rtl/mac_table_lookup.sv | 111 +++++++++++
 tb/tb_mac_table_lookup.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mac_table_lookup_pkg.sv
// Shared types and constants for the read side of the switch MAC table.
package mac_table_lookup_pkg;
  localparam int PORT_NUMBER    = 4;
  localparam int MAC_TABLE_SIZE = 8;
  localparam int PORT_W         = $clog2(PORT_NUMBER);
  localparam int MULTICAST_BIT  = 40;

  typedef logic [47:0] mac_addr_t;
  localparam mac_addr_t BROADCAST = 48'hFFFF_FFFF_FFFF;

  typedef logic [PORT_NUMBER-1:0] port_mask_t;
  typedef logic [PORT_W-1:0]      port_idx_t;

  // An entry equal to BROADCAST is an empty slot.
  typedef struct packed {
    mac_addr_t [MAC_TABLE_SIZE-1:0] mac;
  } port_table_t;

  typedef port_table_t [PORT_NUMBER-1:0] switch_table;

  typedef struct packed {
    mac_addr_t mac;
    logic      valid;
  } lookup_req_t;

  function automatic port_mask_t port_bit(input port_idx_t p);
    return port_mask_t'(1) << p;
  endfunction
endpackage

// File: rtl/mac_table_lookup_if.sv
// Per-port lookup request/grant and result bundle between the port logic and the MAC table reader.
interface mac_table_lookup_if
  import mac_table_lookup_pkg::*;
#(
  parameter int MISS_CNT_W = 32
) ();
  lookup_req_t [PORT_NUMBER-1:0] lookup_req;
  port_mask_t                    lookup_ready;
  port_mask_t                    result_valid;
  port_mask_t [PORT_NUMBER-1:0]  result_mask;
  logic [MISS_CNT_W-1:0]         miss_count;

  modport master (
    output lookup_req,
    input  lookup_ready, result_valid, result_mask, miss_count
  );

  modport slave (
    input  lookup_req,
    output lookup_ready, result_valid, result_mask, miss_count
  );
endinterface

// File: rtl/mac_table_lookup_rr_arbiter.sv
// Round-robin arbiter: one-hot combinational grant searched upward from a registered pointer.
module rr_arbiter #(
  parameter  int N     = 4,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     i_req,
  input  logic             i_advance,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_grant_idx,
  output logic             o_any
);
  localparam logic [IDX_W:0]   N_W  = (IDX_W+1)'(N);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W:0]   w_sum;

  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    o_any       = 1'b0;
    w_sum       = '0;
    for (int k = 0; k < N; k++) begin
      w_sum = {1'b0, r_ptr} + (IDX_W+1)'(k);
      if (w_sum >= N_W) w_sum = w_sum - N_W;
      if (!o_any && i_req[w_sum[IDX_W-1:0]]) begin
        o_any       = 1'b1;
        o_grant_idx = w_sum[IDX_W-1:0];
      end
    end
    if (o_any) o_grant[o_grant_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_advance && o_any) begin
      r_ptr <= (o_grant_idx == LAST) ? '0 : o_grant_idx + IDX_W'(1);
    end
  end
endmodule

// File: rtl/mac_table_lookup.sv
// MAC table read side: arbitrates per-port destination lookups and returns an egress port mask
// two cycles after each transfer, counting unicast misses.
module mac_table_lookup
  import mac_table_lookup_pkg::*;
#(
  parameter int MISS_CNT_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  switch_table         mac_table_in,
  mac_table_lookup_if.slave   lookup
);
  typedef logic [MISS_CNT_W-1:0] miss_cnt_t;

  port_mask_t w_req_valid;
  port_mask_t w_grant;
  port_idx_t  w_grant_idx;
  logic       w_any;
  mac_addr_t  w_req_mac;

  logic       r_vld_p0;
  port_idx_t  r_src_p0;
  mac_addr_t  r_mac_p0;

  port_mask_t w_hit;
  logic       w_is_group;
  port_mask_t w_src_bit;

  port_mask_t                   r_result_valid;
  port_mask_t [PORT_NUMBER-1:0] r_result_mask;
  miss_cnt_t                    r_miss_count;

  // Group or unknown destinations flood; a hit only on the source port drops the frame.
  function automatic port_mask_t egress_mask(input port_mask_t hit, input logic is_group,
                                             input port_mask_t src_bit);
    if (is_group || (hit == '0)) return ~src_bit;
    return hit & ~src_bit;
  endfunction

  function automatic miss_cnt_t sat_inc(input miss_cnt_t c);
    return (&c) ? c : c + MISS_CNT_W'(1);
  endfunction

  // Requests are masked during reset so no grant is issued and ready reads 0.
  always_comb begin
    w_req_valid = '0;
    for (int p = 0; p < PORT_NUMBER; p++) begin
      w_req_valid[p] = lookup.lookup_req[p].valid & ~rst;
    end
  end

  rr_arbiter #(.N(PORT_NUMBER)) u_arb (
    .clk         (clk),
    .rst         (rst),
    .i_req       (w_req_valid),
    .i_advance   (1'b1),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx),
    .o_any       (w_any)
  );

  assign w_req_mac           = lookup.lookup_req[w_grant_idx].mac;
  assign lookup.lookup_ready = w_grant;

  // Stage A -> p0: capture the granted request
  always_ff @(posedge clk) begin
    if (rst) r_vld_p0 <= 1'b0;
    else     r_vld_p0 <= w_any;
  end

  always_ff @(posedge clk) begin
    if (w_any) begin
      r_src_p0 <= w_grant_idx;
      r_mac_p0 <= w_req_mac;
    end
  end

  // Stage B: compare against the table as presented this cycle
  always_comb begin
    w_hit = '0;
    for (int p = 0; p < PORT_NUMBER; p++) begin
      for (int j = 0; j < MAC_TABLE_SIZE; j++) begin
        if ((mac_table_in[p].mac[j] == r_mac_p0) && (mac_table_in[p].mac[j] != BROADCAST)) begin
          w_hit[p] = 1'b1;
        end
      end
    end
  end

  assign w_is_group = r_mac_p0[MULTICAST_BIT];
  assign w_src_bit  = port_bit(r_src_p0);

  // Stage C -> p1: registered result, per-port held mask and miss counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result_valid <= '0;
      r_result_mask  <= '0;
      r_miss_count   <= '0;
    end else begin
      r_result_valid <= r_vld_p0 ? w_src_bit : '0;
      if (r_vld_p0) begin
        r_result_mask[r_src_p0] <= egress_mask(w_hit, w_is_group, w_src_bit);
        if (!w_is_group && (w_hit == '0)) r_miss_count <= sat_inc(r_miss_count);
      end
    end
  end

  assign lookup.result_valid = r_result_valid;
  assign lookup.result_mask  = r_result_mask;
  assign lookup.miss_count   = r_miss_count;
endmodule

// File: tb/tb_mac_table_lookup.sv
// Bench for mac_table_lookup: directed scenarios plus random multi-port traffic against a reference model.
module tb_mac_table_lookup;
  import mac_table_lookup_pkg::*;

  localparam int SAT_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  switch_table tbl;
  switch_table tbl2;

  mac_table_lookup_if #(.MISS_CNT_W(32))    bus ();
  mac_table_lookup_if #(.MISS_CNT_W(SAT_W)) bus2 ();

  mac_table_lookup #(.MISS_CNT_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .mac_table_in (tbl),
    .lookup       (bus)
  );

  mac_table_lookup #(.MISS_CNT_W(SAT_W)) dut_sat (
    .clk          (clk),
    .rst          (rst),
    .mac_table_in (tbl2),
    .lookup       (bus2)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  int         m_ptr;
  logic [31:0] m_miss;
  port_mask_t m_held [PORT_NUMBER];
  bit         pend;
  int         pend_port;
  port_mask_t pend_mask;
  bit         pend_miss;
  int         last_grant;
  int         grant_log [$];

  port_mask_t drv_v;
  mac_addr_t  drv_mac [PORT_NUMBER];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Ports on which the address is learned (empty slots never match).
  function automatic port_mask_t learned_on(input mac_addr_t mac);
    port_mask_t ports = '0;
    for (int p = 0; p < PORT_NUMBER; p++)
      for (int j = 0; j < MAC_TABLE_SIZE; j++)
        if (tbl[p].mac[j] != BROADCAST && tbl[p].mac[j] == mac) ports |= port_mask_t'(1) << p;
    return ports;
  endfunction

  function automatic port_mask_t ref_mask(input int src, input mac_addr_t mac);
    port_mask_t dest = learned_on(mac);
    if (mac[40] || dest == '0) dest = '1;
    dest &= ~(port_mask_t'(1) << src);
    return dest;
  endfunction

  function automatic bit ref_is_miss(input mac_addr_t mac);
    return !mac[40] && (learned_on(mac) == '0);
  endfunction

  function automatic mac_addr_t pick_mac();
    int r = $urandom_range(9, 0);
    mac_addr_t m = {16'($urandom), $urandom};
    if (r < 4)       m = tbl[$urandom_range(PORT_NUMBER-1, 0)].mac[$urandom_range(MAC_TABLE_SIZE-1, 0)];
    else if (r == 4) m = BROADCAST;
    else if (r == 5) m[40] = 1'b1;
    else             m[40] = 1'b0;
    return m;
  endfunction

  task automatic model_reset();
    m_ptr  = 0;
    m_miss = '0;
    pend   = 1'b0;
    for (int p = 0; p < PORT_NUMBER; p++) m_held[p] = '0;
  endtask

  // One clock of traffic: drive requests, check the grant, then check the previous transfer's result.
  task automatic step();
    port_mask_t exp_grant = '0;
    int g = -1;
    for (int p = 0; p < PORT_NUMBER; p++) begin
      bus.lookup_req[p].valid = drv_v[p];
      bus.lookup_req[p].mac   = drv_mac[p];
    end
    #1;
    for (int k = 0; k < PORT_NUMBER; k++) begin
      int p = (m_ptr + k) % PORT_NUMBER;
      if (g < 0 && drv_v[p]) g = p;
    end
    if (g >= 0) exp_grant = port_mask_t'(1) << g;
    check("lookup_ready", 64'(bus.lookup_ready), 64'(exp_grant));
    @(posedge clk);
    #1;
    if (pend) begin
      m_held[pend_port] = pend_mask;
      if (pend_miss) m_miss = m_miss + 32'd1;
    end
    check("result_valid", 64'(bus.result_valid),
          64'(pend ? (port_mask_t'(1) << pend_port) : port_mask_t'(0)));
    for (int p = 0; p < PORT_NUMBER; p++)
      check($sformatf("result_mask[%0d]", p), 64'(bus.result_mask[p]), 64'(m_held[p]));
    check("miss_count", 64'(bus.miss_count), 64'(m_miss));
    last_grant = g;
    pend = (g >= 0);
    if (pend) begin
      pend_port = g;
      pend_mask = ref_mask(g, drv_mac[g]);
      pend_miss = ref_is_miss(drv_mac[g]);
      m_ptr     = (g + 1) % PORT_NUMBER;
      grant_log.push_back(g);
    end
  endtask

  task automatic single(input int port, input mac_addr_t mac);
    drv_v = '0;
    drv_v = drv_v | (port_mask_t'(1) << port);
    drv_mac[port] = mac;
    step();
    drv_v = '0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_grants [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    for (int p = 0; p < PORT_NUMBER; p++) begin
      for (int j = 0; j < MAC_TABLE_SIZE; j++) begin
        tbl[p].mac[j]  = BROADCAST;
        tbl2[p].mac[j] = BROADCAST;
      end
      drv_mac[p] = '0;
      bus.lookup_req[p]  = '0;
      bus2.lookup_req[p] = '0;
    end
    drv_v = '0;
    model_reset();

    // Reset state, with a request pending that must not be granted
    bus.lookup_req[2].valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 64'(bus.lookup_ready), 64'(0));
    check("rst_result_valid", 64'(bus.result_valid), 64'(0));
    check("rst_result_mask", 64'(bus.result_mask), 64'(0));
    check("rst_miss_count", 64'(bus.miss_count), 64'(0));
    check("rst_sat_miss_count", 64'(bus2.miss_count), 64'(0));
    bus.lookup_req[2].valid = 1'b0;
    rst = 1'b0;

    // Empty table: unicast lookup floods and counts a miss
    single(1, 48'h5A01_0101_0101);
    check("tp1_valid", 64'(bus.result_valid), 64'(4'b0010));
    check("tp1_mask", 64'(bus.result_mask[1]), 64'(4'b1101));
    check("tp1_miss", 64'(bus.miss_count), 64'(1));

    // Learned on port 2
    tbl[2].mac[0] = 48'h5A01_0101_0101;
    single(0, 48'h5A01_0101_0101);
    check("tp2_mask", 64'(bus.result_mask[0]), 64'(4'b0100));
    check("tp2_miss", 64'(bus.miss_count), 64'(1));

    // Broadcast then multicast from port 0, back to back
    drv_v = 4'b0001;
    drv_mac[0] = BROADCAST;
    step();
    drv_mac[0] = 48'h0100_5E00_0001;
    step();
    check("tp3_bcast_mask", 64'(bus.result_mask[0]), 64'(4'b1110));
    drv_v = '0;
    step();
    check("tp3_mcast_mask", 64'(bus.result_mask[0]), 64'(4'b1110));
    check("tp3_miss", 64'(bus.miss_count), 64'(1));

    // Destination only on the source port: dropped
    tbl[3].mac[5] = 48'h0200_0000_0033;
    single(3, 48'h0200_0000_0033);
    check("tp4_mask", 64'(bus.result_mask[3]), 64'(4'b0000));
    check("tp4_held_mask1", 64'(bus.result_mask[1]), 64'(4'b1101));

    // All ports requesting continuously from pointer 0
    grant_log.delete();
    drv_v = '1;
    for (int p = 0; p < PORT_NUMBER; p++) drv_mac[p] = pick_mac();
    repeat (8) step();
    drv_v = '0;
    step();
    check("rr_grant_count", 64'(grant_log.size()), 64'(8));
    for (int i = 0; i < 8 && i < grant_log.size(); i++)
      check($sformatf("rr_grant[%0d]", i), 64'(grant_log[i]), 64'(exp_grants[i]));

    // Reset one cycle after a transfer drops the request
    single(1, 48'h0200_0000_0077);
    drv_v = 4'b0100;
    drv_mac[2] = 48'h5A01_0101_0101;
    for (int p = 0; p < PORT_NUMBER; p++) begin
      bus.lookup_req[p].valid = drv_v[p];
      bus.lookup_req[p].mac   = drv_mac[p];
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    drv_v = '0;
    bus.lookup_req[2].valid = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_result_valid", 64'(bus.result_valid), 64'(0));
    check("midrst_result_mask", 64'(bus.result_mask), 64'(0));
    check("midrst_miss_count", 64'(bus.miss_count), 64'(0));
    rst = 1'b0;
    model_reset();
    drv_v = '1;
    step();
    check("midrst_ptr_grant", 64'(last_grant), 64'(0));
    drv_v = '0;
    step();
    step();

    // Random traffic against a random table, including a MAC learned on two ports
    for (int p = 0; p < PORT_NUMBER; p++)
      for (int j = 0; j < MAC_TABLE_SIZE; j++) begin
        mac_addr_t m = {16'($urandom), $urandom};
        m[40] = 1'b0;
        tbl[p].mac[j] = ($urandom_range(3, 0) == 0) ? BROADCAST : m;
      end
    tbl[0].mac[3] = 48'h0211_2233_4455;
    tbl[1].mac[2] = 48'h0211_2233_4455;
    for (int c = 0; c < 200; c++) begin
      for (int p = 0; p < PORT_NUMBER; p++)
        if (!drv_v[p] && $urandom_range(1, 0) == 1) begin
          drv_v = drv_v | (port_mask_t'(1) << p);
          drv_mac[p] = (c % 17 == 0) ? 48'h0211_2233_4455 : pick_mac();
        end
      step();
      if (last_grant >= 0) drv_v = drv_v & ~(port_mask_t'(1) << last_grant);
    end
    drv_v = '0;
    step();
    step();

    // Narrow miss counter: 10 misses, then 10 more saturate at all ones
    bus2.lookup_req[0].mac   = 48'h0200_0000_0099;
    bus2.lookup_req[0].valid = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    bus2.lookup_req[0].valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("sat_miss_10", 64'(bus2.miss_count), 64'(4'hA));
    check("sat_mask0", 64'(bus2.result_mask[0]), 64'(4'b1110));
    bus2.lookup_req[0].valid = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    bus2.lookup_req[0].valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("sat_miss_20", 64'(bus2.miss_count), 64'(4'hF));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
